programmable_fsm: RTL and testbench

Serially programmable Moore state machine for the HeiChips FSM tile. It is a parametrised successor to the fixed-width controller, generalised in state count, input width and output width. Each state has two prioritised masked-match transition rules and its own output word. The transition table is loaded bit-serially over a programming port, after which the machine runs from state 0.

---
 rtl/programmable_fsm.sv | 73 +++++++
 tb/tb_programmable_fsm.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/programmable_fsm.sv
// programmable_fsm: serially loaded Moore FSM, two prioritised masked-match rules per state.
// Optional serial readback of the config register: define PROGRAMMABLE_FSM_READBACK_EN.
module programmable_fsm #(
    parameter int STATE_COUNT = 8,
    parameter int INPUT_WIDTH = 4,
    parameter int OUTPUT_WIDTH = 8,
    localparam int STATE_WIDTH = (STATE_COUNT > 2) ? $clog2(STATE_COUNT) : 1,
    localparam int WORD_WIDTH = OUTPUT_WIDTH + 2 * (2 * INPUT_WIDTH + STATE_WIDTH)
) (
    input  logic                    clock,
    input  logic                    rst,
    input  logic                    prog_enable,
    input  logic                    prog_data,
    input  logic [INPUT_WIDTH-1:0]  in,
    output logic [STATE_WIDTH-1:0]  state,
    output logic [OUTPUT_WIDTH-1:0] out,
    output logic                    changed,
    output logic                    prog_out
);
    localparam int CFG_BITS = STATE_COUNT * WORD_WIDTH;
    localparam logic [STATE_WIDTH:0] LIMIT = STATE_COUNT[STATE_WIDTH:0];

    logic [CFG_BITS-1:0]    cfg_q, cfg_d;
    logic [STATE_WIDTH-1:0] state_q, state_d;
    logic                   changed_q, changed_d;
    logic [WORD_WIDTH-1:0]  words [STATE_COUNT];
    logic [INPUT_WIDTH-1:0] r0_mask, r0_match, r1_mask, r1_match;
    logic [STATE_WIDTH-1:0] r0_next, r1_next, sel_next;
    logic                   r0_hit, r1_hit;

    // Slice the config register into one word per state
    always_comb begin
        for (int s = 0; s < STATE_COUNT; s++) words[s] = cfg_q[s*WORD_WIDTH +: WORD_WIDTH];
    end

    // Decode the current state's word and evaluate its two rules (rule 0 wins)
    always_comb begin
        {out, r1_next, r1_match, r1_mask, r0_next, r0_match, r0_mask} = words[state_q];
        r0_hit = (in & r0_mask) == (r0_match & r0_mask);
        r1_hit = (in & r1_mask) == (r1_match & r1_mask);
        sel_next = r0_hit ? r0_next : (r1_hit ? r1_next : state_q);
    end

    // Next values: shift config while programming, otherwise step the machine
    always_comb begin
        cfg_d = prog_enable ? {cfg_q[CFG_BITS-2:0], prog_data} : cfg_q;
        state_d = (prog_enable || ({1'b0, sel_next} >= LIMIT)) ? '0 : sel_next;
        changed_d = !prog_enable && (state_d != state_q);
    end

    // State, config and change-pulse registers
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            cfg_q <= '0;
            state_q <= '0;
            changed_q <= 1'b0;
        end else begin
            cfg_q <= cfg_d;
            state_q <= state_d;
            changed_q <= changed_d;
        end
    end

    assign state = state_q;
    assign changed = changed_q;

`ifdef PROGRAMMABLE_FSM_READBACK_EN
    assign prog_out = cfg_q[CFG_BITS-1];
`else
    assign prog_out = 1'b0;
`endif

endmodule

// File: tb/tb_programmable_fsm.sv
// tb_programmable_fsm: scoreboard bench for programmable_fsm (default build plus a 5-state build).
module tb_programmable_fsm;
    logic       clock = 0, rst = 0, prog_enable = 0, prog_data = 0;
    logic [3:0] in = 0;
    logic [2:0] state;
    logic [7:0] out;
    logic       changed, prog_out;
    logic       prog_enable5 = 0, prog_data5 = 0;
    logic [3:0] in5 = 0;
    logic [2:0] state5;
    logic [7:0] out5;
    logic       changed5, prog_out5;

    typedef struct packed {
        logic [2:0] st;
        logic [7:0] o;
        logic       ch;
        logic       po;
    } exp_t;

    exp_t         exp_q[$];
    logic [2:0]   q5[$];
    int           n_cmp = 0, n_bad = 0;
    logic [239:0] m_cfg = '0, tbl, pat;
    logic [149:0] t5;
    logic [2:0]   m_state = '0, es;

    always #5 clock = ~clock;

    programmable_fsm u_dut (
        .clock(clock), .rst(rst), .prog_enable(prog_enable), .prog_data(prog_data),
        .in(in), .state(state), .out(out), .changed(changed), .prog_out(prog_out)
    );

    programmable_fsm #(.STATE_COUNT(5)) u_dut5 (
        .clock(clock), .rst(rst), .prog_enable(prog_enable5), .prog_data(prog_data5),
        .in(in5), .state(state5), .out(out5), .changed(changed5), .prog_out(prog_out5)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [29:0] mk(input logic [7:0] o, input logic [2:0] n1, input logic [3:0] m1,
                                       input logic [3:0] k1, input logic [2:0] n0, input logic [3:0] m0,
                                       input logic [3:0] k0);
        return {o, n1, m1, k1, n0, m0, k0};
    endfunction

    function automatic logic [2:0] model_next(input logic [2:0] s, input logic [3:0] i);
        logic [29:0] w;
        w = m_cfg[s*30 +: 30];
        if ((i & w[3:0]) == (w[7:4] & w[3:0])) return w[10:8];
        if ((i & w[14:11]) == (w[18:15] & w[14:11])) return w[21:19];
        return s;
    endfunction

    function automatic logic exp_po();
`ifdef PROGRAMMABLE_FSM_READBACK_EN
        return m_cfg[239];
`else
        return 1'b0;
`endif
    endfunction

    task automatic cyc();
        exp_t e, g;
        logic [2:0] nxt;
        if (prog_enable) begin
            m_cfg = {m_cfg[238:0], prog_data};
            nxt = '0;
            e.ch = 1'b0;
        end else begin
            nxt = model_next(m_state, in);
            e.ch = (nxt != m_state);
        end
        m_state = nxt;
        e.st = nxt;
        e.o = m_cfg[nxt*30+22 +: 8];
        e.po = exp_po();
        exp_q.push_back(e);
        @(posedge clock);
        @(negedge clock);
        g = exp_q.pop_front();
        check("state", {29'b0, state}, {29'b0, g.st});
        check("out", {24'b0, out}, {24'b0, g.o});
        check("changed", {31'b0, changed}, {31'b0, g.ch});
        check("prog_out", {31'b0, prog_out}, {31'b0, g.po});
    endtask

    task automatic run(input logic [3:0] v, input int n);
        in = v;
        repeat (n) cyc();
    endtask

    task automatic load(input logic [239:0] v);
        for (int i = 239; i >= 0; i--) begin
            prog_enable = 1'b1;
            prog_data = v[i];
            cyc();
        end
        prog_enable = 1'b0;
        prog_data = 1'b0;
    endtask

    task automatic do_reset();
        prog_enable = 1'b0;
        prog_enable5 = 1'b0;
        rst = 1'b1;
        #1;
        m_cfg = '0;
        m_state = '0;
        check("rst_state", {29'b0, state}, 32'd0);
        check("rst_out", {24'b0, out}, 32'd0);
        check("rst_changed", {31'b0, changed}, 32'd0);
        check("rst_prog_out", {31'b0, prog_out}, 32'd0);
        @(posedge clock);
        @(negedge clock);
        rst = 1'b0;
    endtask

    initial begin
        in = 4'hF;
        #2;
        do_reset();
        run(4'hF, 10);
        check("idle_state", {29'b0, state}, 32'd0);

        t5 = '0;
        t5[0 +: 30] = mk(8'hF0, 3'd0, 4'h0, 4'h0, 3'd1, 4'b0010, 4'b0010);
        t5[30 +: 30] = mk(8'h11, 3'd0, 4'h0, 4'h0, 3'd7, 4'h0, 4'h0);
        for (int i = 149; i >= 0; i--) begin
            prog_enable5 = 1'b1;
            prog_data5 = t5[i];
            @(posedge clock);
            @(negedge clock);
        end
        prog_enable5 = 1'b0;
        in5 = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            q5.push_back(k[0] ? 3'd0 : 3'd1);
            @(posedge clock);
            @(negedge clock);
            es = q5.pop_front();
            check("oor_state", {29'b0, state5}, {29'b0, es});
            check("oor_out", {24'b0, out5}, (es == 3'd1) ? 32'h11 : 32'hF0);
            check("oor_changed", {31'b0, changed5}, 32'd1);
        end

        tbl = '0;
        tbl[0 +: 30]   = mk(8'h00, 3'd0, 4'b0000, 4'b0001, 3'd1, 4'b0001, 4'b0001);
        tbl[30 +: 30]  = mk(8'hA5, 3'd1, 4'h0, 4'h0, 3'd2, 4'b0010, 4'b0010);
        tbl[60 +: 30]  = mk(8'h3C, 3'd4, 4'h0, 4'h0, 3'd3, 4'b1000, 4'b1000);
        tbl[90 +: 30]  = mk(8'h33, 3'd3, 4'h0, 4'h0, 3'd2, 4'b0100, 4'b0100);
        tbl[120 +: 30] = mk(8'h44, 3'd4, 4'h0, 4'h0, 3'd5, 4'b0100, 4'b0100);
        tbl[150 +: 30] = mk(8'h55, 3'd7, 4'b0010, 4'b0010, 3'd6, 4'b0001, 4'b0001);
        tbl[180 +: 30] = mk(8'h66, 3'd0, 4'h0, 4'h0, 3'd0, 4'h0, 4'h0);
        tbl[210 +: 30] = mk(8'h77, 3'd0, 4'h0, 4'h0, 3'd0, 4'h0, 4'h0);
        load(tbl);

        run(4'b0001, 1);
        check("r0_state", {29'b0, state}, 32'd1);
        check("r0_out", {24'b0, out}, 32'hA5);
        check("r0_pulse", {31'b0, changed}, 32'd1);
        run(4'b0000, 1);
        check("pulse_once", {31'b0, changed}, 32'd0);
        run(4'b0010, 1);
        run(4'b1000, 1);
        check("prio_r0", {29'b0, state}, 32'd3);
        run(4'b0000, 2);
        check("self_no_pulse", {31'b0, changed}, 32'd0);
        run(4'b0100, 1);
        run(4'b0000, 1);
        check("prio_r1", {29'b0, state}, 32'd4);
        run(4'b0100, 1);
        run(4'b0000, 3);
        check("hold_state", {29'b0, state}, 32'd5);
        check("hold_changed", {31'b0, changed}, 32'd0);
        run(4'b0011, 1);
        check("both_hit_r0", {29'b0, state}, 32'd6);
        run(4'b0000, 1);
        run(4'b0001, 1);
        run(4'b0010, 1);
        run(4'b1000, 1);
        check("pre_prog_state", {29'b0, state}, 32'd3);

        for (int i = 0; i < 100; i++) begin
            prog_enable = 1'b1;
            prog_data = 1'($urandom_range(1, 0));
            cyc();
            if (i == 0) begin
                check("prog_entry_state", {29'b0, state}, 32'd0);
                check("prog_entry_changed", {31'b0, changed}, 32'd0);
            end
        end
        do_reset();
        run(4'hF, 5);

        for (int i = 0; i < 240; i++) pat[i] = 1'($urandom_range(1, 0));
        load(pat);
        load('0);
        run(4'h5, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
